// File: rtl/sort_pkg.sv
// Shared definitions for the sorter result streamer: default sizing,
// index width helper and the streamer state encoding.
package sort_pkg;

  localparam int DEF_NUM_VALS = 8;
  localparam int DEF_SIZE     = 8;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/sort_order_checker.sv
// On-the-fly sort-order monitor: remembers the previously accepted element and
// raises a sticky flag when an accepted element breaks the requested order.
module sort_order_checker #(
  parameter int SIZE    = 8,
  parameter bit DESCEND = 1'b0
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            beat_fire,
  input  logic            first_beat,
  input  logic            clr,
  input  logic [SIZE-1:0] data,
  output logic            order_err
);

  logic [SIZE-1:0] prev_q, prev_d;
  logic            err_q, err_d;
  logic            viol;

  always_comb begin
    viol   = DESCEND ? (data > prev_q) : (data < prev_q);
    prev_d = prev_q;
    err_d  = err_q;
    if (beat_fire) prev_d = data;
    // Flag survives into the first beat of the next frame and drops once that beat is taken.
    if (clr || (beat_fire && first_beat)) err_d = 1'b0;
    else if (beat_fire && viol)           err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign order_err = err_q;

endmodule

// File: rtl/sort_result_streamer.sv
// Captures one packed frame from the sorter and streams it out element by
// element (index 0 first) on a valid/ready interface, checking order as it goes.
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter int NUM_VALS = DEF_NUM_VALS,
  parameter int SIZE     = DEF_SIZE,
  parameter bit DESCEND  = 1'b0,
  localparam int IDX_W   = idx_w(NUM_VALS)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_VALS*SIZE-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     order_err,
  output logic                     busy
);

  state_e                          state_q, state_d;
  logic [NUM_VALS-1:0][SIZE-1:0]   frame_q, frame_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            fire, is_last, accept, idle_accept;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    out_valid   = (state_q == STREAM);
    is_last     = (idx_q == IDX_W'(NUM_VALS - 1));
    fire        = out_valid && out_ready;
    in_ready    = rst_n && ((state_q == IDLE) || (fire && is_last));
    accept      = in_valid && in_ready;
    idle_accept = accept && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = in_data;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire) begin
          if (!is_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = '0;
            // Back-to-back frames reload here without a bubble cycle.
            if (accept) frame_d = in_data;
            else        state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  assign out_data = out_valid ? frame_q[idx_q] : '0;
  assign out_idx  = idx_q;
  assign out_last = out_valid && is_last;
  assign busy     = out_valid;

  sort_order_checker #(
    .SIZE    (SIZE),
    .DESCEND (DESCEND)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_fire  (fire),
    .first_beat (idx_q == '0),
    .clr        (idle_accept),
    .data       (out_data),
    .order_err  (order_err)
  );

endmodule
